// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM stage controller
// Purpose: state encoding and width defaults used by mem_stage_ctrl and mem_wb_reg.
// Contents: DWL_DEF (default data/address width), REG_AW (register index width),
//           state_t (MEM stage FSM states IDLE / ACCESS).
package mem_stage_pkg;

   localparam int DWL_DEF = 32;
   localparam int REG_AW  = 5;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load and bubble controls
// Purpose: holds the writeback-stage copy of the MEM stage results.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   load              capture rfwe/mtorfsel/rtd/aluout, clear the error flag
//   load_dm           with load: also capture dmrdata into dmout_w
//   bubble            write-disable the slot (rfwe_w=0), error flag := err
//   err               access-timeout flag presented with a bubble
//   rfwe, mtorfsel, rtd, aluout, dmrdata   MEM stage values
//   rfwe_w, mtorfsel_w, rtd_w, aluout_w, dmout_w, mem_err_w   registered outputs
module mem_wb_reg
   import mem_stage_pkg::*;
#(
   parameter int DWL = DWL_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              load_dm,
   input  logic              bubble,
   input  logic              err,
   input  logic              rfwe,
   input  logic              mtorfsel,
   input  logic [REG_AW-1:0] rtd,
   input  logic [DWL-1:0]    aluout,
   input  logic [DWL-1:0]    dmrdata,
   output logic              rfwe_w,
   output logic              mtorfsel_w,
   output logic [REG_AW-1:0] rtd_w,
   output logic [DWL-1:0]    aluout_w,
   output logic [DWL-1:0]    dmout_w,
   output logic              mem_err_w
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rfwe_w     <= 1'b0;
         mtorfsel_w <= 1'b0;
         rtd_w      <= '0;
         aluout_w   <= '0;
         dmout_w    <= '0;
         mem_err_w  <= 1'b0;
      end else if (load) begin
         rfwe_w     <= rfwe;
         mtorfsel_w <= mtorfsel;
         rtd_w      <= rtd;
         aluout_w   <= aluout;
         mem_err_w  <= 1'b0;
         // Load data is only meaningful on a completed load; otherwise keep it.
         if (load_dm) begin
            dmout_w <= dmrdata;
         end
      end else if (bubble) begin
         // Only the write enable matters for a bubble; data fields may hold.
         rfwe_w    <= 1'b0;
         mem_err_w <= err;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage controller: branch resolve, data-memory req/ack, MEM/WB
// Purpose: consumes the EX/MEM lines, resolves the branch, runs a req/ack access
//          for loads/stores while stalling upstream, and fills the MEM/WB lines.
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT
//          ACCESS cycles without DMAck (flagged on MemErrW).
// Ports:
//   CLK, RSTN                           clock, asynchronous active-low reset
//   RFWEM, MtoRFSelM, DMWEM, BranchM, ZeroM, rtdM, ALUOutM, DMdinM, PCBranchM
//                                       EX/MEM lines
//   DMAck, DMRdata                      memory completion and load data
//   StallM                              hold EX/MEM and earlier stages
//   PCSrcM, PCBranchO                   branch decision and target to fetch
//   DMReq, DMWE, DMAddr, DMWdata        data-memory request port
//   RFWEW, MtoRFSelW, rtdW, ALUOutW, DMoutW, MemErrW   MEM/WB lines
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int DWL     = DWL_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              RFWEM,
   input  logic              MtoRFSelM,
   input  logic              DMWEM,
   input  logic              BranchM,
   input  logic              ZeroM,
   input  logic [REG_AW-1:0] rtdM,
   input  logic [DWL-1:0]    ALUOutM,
   input  logic [DWL-1:0]    DMdinM,
   input  logic [DWL-1:0]    PCBranchM,
   input  logic              DMAck,
   input  logic [DWL-1:0]    DMRdata,
   output logic              StallM,
   output logic              PCSrcM,
   output logic [DWL-1:0]    PCBranchO,
   output logic              DMReq,
   output logic              DMWE,
   output logic [DWL-1:0]    DMAddr,
   output logic [DWL-1:0]    DMWdata,
   output logic              RFWEW,
   output logic              MtoRFSelW,
   output logic [REG_AW-1:0] rtdW,
   output logic [DWL-1:0]    ALUOutW,
   output logic [DWL-1:0]    DMoutW,
   output logic              MemErrW
);

   state_t state, state_nxt;
   logic   memop;
   logic   stall_c, req_c;
   logic   wb_load, wb_load_dm, wb_bubble, wb_err;
   logic   timeout_hit;

   assign memop = MtoRFSelM | DMWEM;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      stall_c    = 1'b0;
      req_c      = 1'b0;
      wb_load    = 1'b0;
      wb_load_dm = 1'b0;
      wb_bubble  = 1'b0;
      wb_err     = 1'b0;
      case (state)
         IDLE: begin
            // A memop always spends one IDLE cycle before requesting, which
            // also guarantees a gap between back-to-back requests.
            if (memop) begin
               stall_c   = 1'b1;
               wb_bubble = 1'b1;
               state_nxt = ACCESS;
            end else begin
               wb_load = 1'b1;
            end
         end
         ACCESS: begin
            if (DMAck) begin
               // Ack wins over a coincident timeout.
               req_c      = 1'b1;
               wb_load    = 1'b1;
               wb_load_dm = MtoRFSelM;
               state_nxt  = IDLE;
            end else if (timeout_hit) begin
               wb_bubble = 1'b1;
               wb_err    = 1'b1;
               state_nxt = IDLE;
            end else begin
               req_c     = 1'b1;
               stall_c   = 1'b1;
               wb_bubble = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   logic [CW-1:0] to_cnt;

   // Held at zero in IDLE, so it is clear on every entry to ACCESS.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         to_cnt <= '0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if (!DMAck && !timeout_hit) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_hit = (to_cnt == CW'(TIMEOUT));
`else
   // No timeout in this build; folds to constant 0.
   assign timeout_hit = (TIMEOUT < 0);
`endif

   // Request and stall are forced low while reset is held, whatever the M lines say.
   assign StallM    = stall_c & RSTN;
   assign DMReq     = req_c & RSTN;
   assign DMWE      = DMReq & DMWEM;
   assign DMAddr    = ALUOutM;
   assign DMWdata   = DMdinM;
   assign PCSrcM    = BranchM & ZeroM & ~StallM;
   assign PCBranchO = PCBranchM;

   mem_wb_reg #(
      .DWL (DWL)
   ) u_mem_wb_reg (
      .clk        (CLK),
      .rst_n      (RSTN),
      .load       (wb_load),
      .load_dm    (wb_load_dm),
      .bubble     (wb_bubble),
      .err        (wb_err),
      .rfwe       (RFWEM),
      .mtorfsel   (MtoRFSelM),
      .rtd        (rtdM),
      .aluout     (ALUOutM),
      .dmrdata    (DMRdata),
      .rfwe_w     (RFWEW),
      .mtorfsel_w (MtoRFSelW),
      .rtd_w      (rtdW),
      .aluout_w   (ALUOutW),
      .dmout_w    (DMoutW),
      .mem_err_w  (MemErrW)
   );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl (directed + randomized)
module tb_mem_stage_ctrl;

   localparam int DWL = 32;
   localparam int TO  = 15;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           CLK = 1'b0;
   logic           RSTN;
   logic           RFWEM, MtoRFSelM, DMWEM, BranchM, ZeroM;
   logic [4:0]     rtdM;
   logic [DWL-1:0] ALUOutM, DMdinM, PCBranchM;
   logic           DMAck;
   logic [DWL-1:0] DMRdata;
   logic           StallM, PCSrcM;
   logic [DWL-1:0] PCBranchO;
   logic           DMReq, DMWE;
   logic [DWL-1:0] DMAddr, DMWdata;
   logic           RFWEW, MtoRFSelW;
   logic [4:0]     rtdW;
   logic [DWL-1:0] ALUOutW, DMoutW;
   logic           MemErrW;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 CLK = ~CLK;

   mem_stage_ctrl #(.DWL(DWL), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RSTN(RSTN), .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .DMWEM(DMWEM),
      .BranchM(BranchM), .ZeroM(ZeroM), .rtdM(rtdM), .ALUOutM(ALUOutM), .DMdinM(DMdinM),
      .PCBranchM(PCBranchM), .DMAck(DMAck), .DMRdata(DMRdata), .StallM(StallM),
      .PCSrcM(PCSrcM), .PCBranchO(PCBranchO), .DMReq(DMReq), .DMWE(DMWE),
      .DMAddr(DMAddr), .DMWdata(DMWdata), .RFWEW(RFWEW), .MtoRFSelW(MtoRFSelW),
      .rtdW(rtdW), .ALUOutW(ALUOutW), .DMoutW(DMoutW), .MemErrW(MemErrW)
   );

   task automatic idle_inputs;
      RFWEM = 0; MtoRFSelM = 0; DMWEM = 0; BranchM = 0; ZeroM = 0;
      rtdM = 0; ALUOutM = 0; DMdinM = 0; PCBranchM = 0; DMAck = 0; DMRdata = 0;
   endtask

   task automatic test_reset;
      RSTN = 0;
      idle_inputs();
      MtoRFSelM = 1;
      @(negedge CLK); #1;
      tests_run++; if (StallM !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", StallM); end
      tests_run++; if (DMReq !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b want 0", DMReq); end
      tests_run++;
      if ({RFWEW, MtoRFSelW, rtdW, ALUOutW, DMoutW, MemErrW} !== '0) begin
         tests_failed++;
         $display("FAIL reset_wb got rfwe=%b sel=%b rtd=%h alu=%h dm=%h err=%b want all 0",
                  RFWEW, MtoRFSelW, rtdW, ALUOutW, DMoutW, MemErrW);
      end
      @(negedge CLK);
      idle_inputs();
      RSTN = 1;
      @(negedge CLK);
   endtask

   task automatic test_alu_op;
      @(negedge CLK);
      RFWEM = 1; rtdM = 5; ALUOutM = 32'h1234; DMAck = 1;
      #1;
      tests_run++; if (StallM !== 1'b0) begin tests_failed++; $display("FAIL alu_stall got %b want 0", StallM); end
      tests_run++; if (DMReq !== 1'b0) begin tests_failed++; $display("FAIL alu_req_idle_ack got %b want 0", DMReq); end
      @(negedge CLK);
      idle_inputs();
      #1;
      tests_run++;
      if (RFWEW !== 1'b1 || rtdW !== 5'd5 || ALUOutW !== 32'h1234) begin
         tests_failed++;
         $display("FAIL alu_wb got rfwe=%b rtd=%0d alu=%h want 1 5 1234", RFWEW, rtdW, ALUOutW);
      end
   endtask

   task automatic test_load;
      int stall_n, sreq_n, ack_req, wb_early;
      stall_n = 0; sreq_n = 0; ack_req = 0; wb_early = 0;
      @(negedge CLK);
      MtoRFSelM = 1; RFWEM = 1; rtdM = 7; ALUOutM = 32'h40;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge CLK);
         DMAck   = (c == 4);
         DMRdata = (c == 4) ? 32'hDEADBEEF : 32'h0BAD0BAD;
         #1;
         if (RFWEW) wb_early++;
         if (DMReq && DMAddr !== 32'h40) wb_early++;
         if (StallM) begin
            stall_n++;
            if (DMReq) sreq_n++;
         end else begin
            if (DMReq) ack_req++;
            break;
         end
      end
      tests_run++; if (stall_n != 4) begin tests_failed++; $display("FAIL load_stall_cycles got %0d want 4", stall_n); end
      tests_run++; if (sreq_n != 3) begin tests_failed++; $display("FAIL load_req_stalled got %0d want 3", sreq_n); end
      tests_run++; if (ack_req != 1) begin tests_failed++; $display("FAIL load_req_ack got %0d want 1", ack_req); end
      tests_run++; if (wb_early != 0) begin tests_failed++; $display("FAIL load_early_wb_or_addr got %0d want 0", wb_early); end
      @(negedge CLK);
      idle_inputs();
      #1;
      tests_run++;
      if (DMoutW !== 32'hDEADBEEF || RFWEW !== 1'b1 || rtdW !== 5'd7 || MtoRFSelW !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_wb got dm=%h rfwe=%b rtd=%0d sel=%b want deadbeef 1 7 1", DMoutW, RFWEW, rtdW, MtoRFSelW);
      end
      @(negedge CLK); #1;
      tests_run++; if (RFWEW !== 1'b0) begin tests_failed++; $display("FAIL load_wb_once got %b want 0", RFWEW); end
      tests_run++; if (DMoutW !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_dm_hold got %h want deadbeef", DMoutW); end
   endtask

   task automatic test_store;
      @(negedge CLK);
      DMWEM = 1; ALUOutM = 32'h80; DMdinM = 32'hCAFE0001; DMAck = 0;
      #1;
      tests_run++;
      if (StallM !== 1'b1 || DMReq !== 1'b0) begin
         tests_failed++; $display("FAIL store_idle got stall=%b req=%b want 1 0", StallM, DMReq);
      end
      @(negedge CLK);
      DMAck = 1;
      #1;
      tests_run++;
      if (DMReq !== 1'b1 || DMWE !== 1'b1 || StallM !== 1'b0 || DMAddr !== 32'h80 || DMWdata !== 32'hCAFE0001) begin
         tests_failed++;
         $display("FAIL store_access got req=%b we=%b stall=%b addr=%h wd=%h want 1 1 0 80 cafe0001",
                  DMReq, DMWE, StallM, DMAddr, DMWdata);
      end
      @(negedge CLK);
      idle_inputs();
      #1;
      tests_run++;
      if (RFWEW !== 1'b0 || DMReq !== 1'b0) begin
         tests_failed++; $display("FAIL store_after got rfwe=%b req=%b want 0 0", RFWEW, DMReq);
      end
   endtask

   task automatic test_branch;
      @(negedge CLK);
      BranchM = 1; ZeroM = 1; PCBranchM = 32'h100;
      #1;
      tests_run++;
      if (PCSrcM !== 1'b1 || PCBranchO !== 32'h100) begin
         tests_failed++; $display("FAIL branch_taken got src=%b tgt=%h want 1 100", PCSrcM, PCBranchO);
      end
      ZeroM = 0;
      #1;
      tests_run++; if (PCSrcM !== 1'b0) begin tests_failed++; $display("FAIL branch_not_taken got %b want 0", PCSrcM); end
      ZeroM = 1; MtoRFSelM = 1;
      #1;
      tests_run++; if (PCSrcM !== 1'b0) begin tests_failed++; $display("FAIL branch_masked_by_stall got %b want 0", PCSrcM); end
      @(negedge CLK);
      DMAck = 1;
      @(negedge CLK);
      idle_inputs();
   endtask

   task automatic test_reset_mid_access;
      @(negedge CLK);
      RFWEM = 1; rtdM = 3; ALUOutM = 32'hA5A5;
      @(negedge CLK);
      MtoRFSelM = 1; ALUOutM = 32'h44;
      @(negedge CLK); #1;
      tests_run++; if (DMReq !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre_req got %b want 1", DMReq); end
      RSTN = 0;
      #1;
      tests_run++;
      if (DMReq !== 1'b0 || StallM !== 1'b0) begin
         tests_failed++; $display("FAIL rst_mid_ctrl got req=%b stall=%b want 0 0", DMReq, StallM);
      end
      tests_run++;
      if ({RFWEW, MtoRFSelW, rtdW, ALUOutW, DMoutW, MemErrW} !== '0) begin
         tests_failed++;
         $display("FAIL rst_mid_wb got rfwe=%b rtd=%h alu=%h dm=%h want all 0", RFWEW, rtdW, ALUOutW, DMoutW);
      end
      @(negedge CLK);
      RSTN = 1;
      #1;
      tests_run++;
      if (DMReq !== 1'b0 || StallM !== 1'b1) begin
         tests_failed++; $display("FAIL rst_mid_idle got req=%b stall=%b want 0 1", DMReq, StallM);
      end
      @(negedge CLK);
      DMAck = 1;
      @(negedge CLK);
      idle_inputs();
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout;
      int stall_n, sreq_n, abort_req;
      bit done;
      stall_n = 0; sreq_n = 0; abort_req = 0; done = 0;
      @(negedge CLK);
      MtoRFSelM = 1; RFWEM = 1; rtdM = 2; ALUOutM = 32'h90; DMAck = 0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge CLK);
         #1;
         if (StallM) begin
            stall_n++;
            if (DMReq) sreq_n++;
         end else begin
            if (DMReq) abort_req++;
            done = 1;
            break;
         end
      end
      tests_run++; if (!done) begin tests_failed++; $display("FAIL timeout_bound got no abort want abort within 40"); end
      tests_run++; if (stall_n != 16) begin tests_failed++; $display("FAIL timeout_stall got %0d want 16", stall_n); end
      tests_run++; if (sreq_n != 15 || abort_req != 0) begin
         tests_failed++; $display("FAIL timeout_req got %0d/%0d want 15/0", sreq_n, abort_req);
      end
      @(negedge CLK);
      idle_inputs();
      RFWEM = 1; rtdM = 9; ALUOutM = 32'h55;
      #1;
      tests_run++;
      if (MemErrW !== 1'b1 || RFWEW !== 1'b0 || StallM !== 1'b0) begin
         tests_failed++; $display("FAIL timeout_err got err=%b rfwe=%b stall=%b want 1 0 0", MemErrW, RFWEW, StallM);
      end
      @(negedge CLK);
      idle_inputs();
      #1;
      tests_run++;
      if (MemErrW !== 1'b0 || RFWEW !== 1'b1 || rtdW !== 5'd9) begin
         tests_failed++; $display("FAIL timeout_next got err=%b rfwe=%b rtd=%0d want 0 1 9", MemErrW, RFWEW, rtdW);
      end
   endtask
`else
   task automatic test_no_timeout;
      int stall_n, err_n;
      stall_n = 0; err_n = 0;
      @(negedge CLK);
      DMWEM = 1; ALUOutM = 32'h70; DMAck = 0;
      for (int c = 0; c < 31; c++) begin
         if (c > 0) @(negedge CLK);
         #1;
         if (StallM) stall_n++;
         if (MemErrW) err_n++;
      end
      tests_run++; if (stall_n != 31) begin tests_failed++; $display("FAIL notimeout_stall got %0d want 31", stall_n); end
      tests_run++; if (err_n != 0) begin tests_failed++; $display("FAIL notimeout_err got %0d want 0", err_n); end
      @(negedge CLK);
      DMAck = 1;
      #1;
      tests_run++;
      if (StallM !== 1'b0 || DMReq !== 1'b1) begin
         tests_failed++; $display("FAIL notimeout_ack got stall=%b req=%b want 0 1", StallM, DMReq);
      end
      @(negedge CLK);
      idle_inputs();
   endtask
`endif

   // Transaction-level model: each instruction is held on the M lines until it
   // retires. A memop with d ack-less ACCESS cycles spends one IDLE cycle, d
   // waiting cycles, and retires on the ack cycle (or aborts on ACCESS cycle TO+1).
   task automatic test_random;
      bit             e_rfwe, e_sel, e_err, e_valid;
      logic [4:0]     e_rtd;
      logic [DWL-1:0] e_alu, e_dm;
      int             kind, d, ev;
      bit             memop, done, e_stall, e_req;
      logic           i_rfwe, i_br, i_zero;
      logic [4:0]     i_rtd;
      logic [DWL-1:0] i_alu, i_din, i_pcb;

      @(negedge CLK);
      RSTN = 0;
      idle_inputs();
      @(negedge CLK);
      RSTN = 1;
      e_rfwe = 0; e_sel = 0; e_err = 0; e_valid = 1; e_rtd = 0; e_alu = 0; e_dm = 0;

      for (int i = 0; i < 80; i++) begin
         kind   = $urandom_range(0, 2);
         memop  = (kind != 0);
         d      = $urandom_range(0, 4);
         if (TO_EN && $urandom_range(0, 5) == 0) d = $urandom_range(TO - 1, TO + 3);
         i_rfwe = $urandom_range(0, 1);
         i_br   = $urandom_range(0, 1);
         i_zero = $urandom_range(0, 1);
         i_rtd  = 5'($urandom);
         i_alu  = $urandom;
         i_din  = $urandom;
         i_pcb  = $urandom;
         done   = 0;
         for (int k = 0; !done && k < 64; k++) begin
            @(negedge CLK);
            RFWEM = i_rfwe; MtoRFSelM = (kind == 1); DMWEM = (kind == 2);
            BranchM = i_br; ZeroM = i_zero; rtdM = i_rtd;
            ALUOutM = i_alu; DMdinM = i_din; PCBranchM = i_pcb;
            DMRdata = $urandom;
            if (memop && k >= 1) DMAck = (k == d + 1);
            else DMAck = $urandom_range(0, 1);

            if (!memop) begin
               e_stall = 0; e_req = 0; ev = 0; done = 1;
            end else if (k == 0) begin
               e_stall = 1; e_req = 0; ev = 1;
            end else if (k == d + 1) begin
               e_stall = 0; e_req = 1; ev = 0; done = 1;
            end else if (TO_EN && k == TO + 1) begin
               e_stall = 0; e_req = 0; ev = 2; done = 1;
            end else begin
               e_stall = 1; e_req = 1; ev = 1;
            end

            #1;
            tests_run++;
            if (StallM !== e_stall || DMReq !== e_req) begin
               tests_failed++;
               $display("FAIL rnd_ctrl op%0d k%0d got stall=%b req=%b want %b %b", i, k, StallM, DMReq, e_stall, e_req);
            end
            tests_run++;
            if (e_req && (DMWE !== (kind == 2) || DMAddr !== i_alu || DMWdata !== i_din)) begin
               tests_failed++;
               $display("FAIL rnd_port op%0d got we=%b addr=%h wd=%h want %b %h %h", i, DMWE, DMAddr, DMWdata, (kind == 2), i_alu, i_din);
            end
            tests_run++;
            if (PCSrcM !== (i_br & i_zero & ~e_stall) || PCBranchO !== i_pcb) begin
               tests_failed++;
               $display("FAIL rnd_branch op%0d got src=%b tgt=%h want %b %h", i, PCSrcM, PCBranchO, i_br & i_zero & ~e_stall, i_pcb);
            end
            tests_run++;
            if (RFWEW !== e_rfwe || MemErrW !== e_err) begin
               tests_failed++;
               $display("FAIL rnd_wb_ctl op%0d k%0d got rfwe=%b err=%b want %b %b", i, k, RFWEW, MemErrW, e_rfwe, e_err);
            end
            tests_run++;
            if (e_valid && (MtoRFSelW !== e_sel || rtdW !== e_rtd || ALUOutW !== e_alu || DMoutW !== e_dm)) begin
               tests_failed++;
               $display("FAIL rnd_wb_data op%0d got sel=%b rtd=%h alu=%h dm=%h want %b %h %h %h",
                        i, MtoRFSelW, rtdW, ALUOutW, DMoutW, e_sel, e_rtd, e_alu, e_dm);
            end

            if (ev == 0) begin
               e_rfwe = i_rfwe; e_sel = (kind == 1); e_rtd = i_rtd; e_alu = i_alu;
               e_err = 0; e_valid = 1;
               if (kind == 1) e_dm = DMRdata;
            end else if (ev == 1) begin
               e_rfwe = 0; e_err = 0; e_valid = 0;
            end else begin
               e_rfwe = 0; e_err = 1; e_valid = 0;
            end
         end
      end
      @(negedge CLK);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alu_op();
      test_load();
      test_store();
      test_branch();
      test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
